// File: rtl/fb_pkg.sv
// Shared constants, FSM encoding and address helper for the frame-buffer write-port arbiter.
package fb_pkg;
  localparam int FB_W     = 640;
  localparam int FB_H     = 480;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W   = 19;
  localparam int PIX_W    = 12;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_e;

  function automatic logic [ADDR_W-1:0] xy2addr(input logic [9:0] x, input logic [8:0] y);
    return ADDR_W'(x) + ADDR_W'(y) * ADDR_W'(FB_W);
  endfunction
endpackage

// File: rtl/fb_port_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone valid wins, a tie goes to the side that did not win last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);
  // last=1 means r1 won most recently, so r0 takes the tie.
  assign grant[0] = valid[0] & (~valid[1] | last);
  assign grant[1] = valid[1] & (~valid[0] | ~last);
endmodule

// File: rtl/fb_port_arbiter.sv
// Owns RAM write port A: round-robin between loader (r0) and k-means (r1), plus a full-buffer clear.
// Optional FB_VBLANK_GATE_EN adds a vblank input that stalls all writes while it is low.
module fb_port_arbiter #(
  parameter int FB_DEPTH = fb_pkg::FB_DEPTH,
  parameter int ADDR_W   = fb_pkg::ADDR_W,
  parameter int PIX_W    = fb_pkg::PIX_W
) (
  input  logic              clk,
  input  logic              rst,
`ifdef FB_VBLANK_GATE_EN
  input  logic              vblank,
`endif
  input  logic              clr_start,
  input  logic [PIX_W-1:0]  clr_color,
  output logic              clr_busy,
  input  logic              r0_valid,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [PIX_W-1:0]  r0_data,
  output logic              r0_ready,
  input  logic              r1_valid,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [PIX_W-1:0]  r1_data,
  output logic              r1_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [PIX_W-1:0]  dina,
  output logic              oob_drop
);
  import fb_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  fb_state_e         state_q, state_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0]  color_q, color_d;
  logic              busy_q, busy_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [PIX_W-1:0]  dina_q, dina_d;
  logic              oob_q, oob_d;

  logic              gate, clr_acc;
  logic [1:0]        grant, ready;
  logic [ADDR_W-1:0] req_addr;
  logic [PIX_W-1:0]  req_data;

`ifdef FB_VBLANK_GATE_EN
  assign gate = vblank;
`else
  assign gate = 1'b1;
`endif

  rr_arb2 u_rr (
    .valid ({r1_valid, r0_valid}),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    // busy_q also covers the cycle after the FSM returns to ARB, while the last fill write is on the port.
    clr_acc  = clr_start & (state_q == ST_ARB) & ~busy_q;
    ready    = (state_q == ST_ARB && !clr_acc && gate) ? grant : 2'b00;
    req_addr = ready[1] ? r1_addr : r0_addr;
    req_data = ready[1] ? r1_data : r0_data;

    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    wea_d   = 1'b0;
    addra_d = addra_q;
    dina_d  = dina_q;
    oob_d   = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (clr_acc) begin
          state_d = ST_CLEAR;
          color_d = clr_color;
          cnt_d   = '0;
          // Address 0 is issued on the accept edge so the fill starts on the port one cycle later.
          if (gate) begin
            wea_d   = 1'b1;
            addra_d = '0;
            dina_d  = clr_color;
            cnt_d   = ADDR_W'(1);
          end
        end else if (|ready) begin
          last_d = ready[1];
          if (req_addr <= LAST_ADDR) begin
            wea_d   = 1'b1;
            addra_d = req_addr;
            dina_d  = req_data;
          end else begin
            oob_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (gate) begin
          wea_d   = 1'b1;
          addra_d = cnt_q;
          dina_d  = color_q;
          if (cnt_q == LAST_ADDR) state_d = ST_ARB;
          else                    cnt_d   = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_ARB;
    endcase

    busy_d = (state_d == ST_CLEAR) | (state_q == ST_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARB;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      color_q <= '0;
      busy_q  <= 1'b0;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      busy_q  <= busy_d;
      wea_q   <= wea_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
      oob_q   <= oob_d;
    end
  end

  assign r0_ready = ready[0];
  assign r1_ready = ready[1];
  assign clr_busy = busy_q;
  assign wea      = wea_q;
  assign addra    = addra_q;
  assign dina     = dina_q;
  assign oob_drop = oob_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a per-cycle reference model (reduced FB_DEPTH).
module tb_fb_port_arbiter;
  localparam int D  = 2000;
  localparam int AW = 19;
  localparam int PW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_start;
  logic [PW-1:0] clr_color;
  logic          clr_busy;
  logic          r0_valid, r1_valid, r0_ready, r1_ready;
  logic [AW-1:0] r0_addr, r1_addr, addra;
  logic [PW-1:0] r0_data, r1_data, dina;
  logic          wea, oob_drop;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fb_port_arbiter #(.FB_DEPTH(D), .ADDR_W(AW), .PIX_W(PW)) dut (
    .clk(clk), .rst(rst),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(r1_ready),
    .wea(wea), .addra(addra), .dina(dina), .oob_drop(oob_drop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: tracks remaining fill writes and the last winner, predicts next-cycle port state.
  bit            mdl_on = 0;
  bit            lastw;
  int            clr_left, clr_addr;
  logic [PW-1:0] clr_col;
  bit            e_wea, e_oob, e_busy;
  int            e_addr;
  logic [PW-1:0] e_data;

  always @(negedge clk) begin
    bit       acc, blocked;
    bit [1:0] er;
    int       a;
    if (mdl_on) begin
      chk("m_wea", 32'(wea), 32'(e_wea));
      chk("m_oob", 32'(oob_drop), 32'(e_oob));
      chk("m_busy", 32'(clr_busy), 32'(e_busy));
      if (e_wea) begin
        chk("m_addra", 32'(addra), 32'(e_addr));
        chk("m_dina", 32'(dina), 32'(e_data));
      end
    end
    if (rst) begin
      mdl_on = 1; lastw = 1; clr_left = 0; clr_addr = 0; clr_col = '0;
      e_wea = 0; e_oob = 0; e_busy = 0; e_addr = 0; e_data = '0;
    end else if (mdl_on) begin
      acc     = clr_start && !e_busy && clr_left == 0;
      blocked = clr_left > 0 || acc;
      er      = 2'b00;
      if (!blocked) begin
        if (r0_valid && r1_valid) er = lastw ? 2'b01 : 2'b10;
        else                      er = {r1_valid, r0_valid};
      end
      chk("m_ready", 32'({r1_ready, r0_ready}), 32'(er));
      e_oob = 0;
      e_wea = 0;
      e_busy = 0;
      if (clr_left > 0) begin
        e_wea = 1; e_addr = clr_addr; e_data = clr_col; e_busy = 1;
        clr_addr++; clr_left--;
      end else if (acc) begin
        clr_col = clr_color;
        e_wea = 1; e_addr = 0; e_data = clr_color; e_busy = 1;
        clr_addr = 1; clr_left = D - 1;
      end else if (er != 2'b00) begin
        lastw = er[1];
        a = er[1] ? int'(r1_addr) : int'(r0_addr);
        if (a < D) begin
          e_wea = 1; e_addr = a; e_data = er[1] ? r1_data : r0_data;
        end else begin
          e_oob = 1;
        end
      end
    end
  end

  initial begin
    int busy_cnt, good, first_rdy, exp_a;
    bit found;
    logic [1:0] grants [4];
    rst = 1; clr_start = 0; clr_color = '0;
    r0_valid = 0; r0_addr = '0; r0_data = '0;
    r1_valid = 0; r1_addr = '0; r1_data = '0;
    grants = '{2'b01, 2'b10, 2'b01, 2'b10};
    repeat (3) cyc();
    rst = 0;
    #2;
    chk("rst_wea", 32'(wea), 0);
    chk("rst_addra", 32'(addra), 0);
    chk("rst_dina", 32'(dina), 0);
    chk("rst_busy", 32'(clr_busy), 0);
    chk("rst_oob", 32'(oob_drop), 0);
    cyc();

    // Both requesters contend: alternating grants from reset, r0 first.
    r0_valid = 1; r0_addr = 10; r0_data = 12'h111;
    r1_valid = 1; r1_addr = 20; r1_data = 12'h222;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("rr_grant", 32'({r1_ready, r0_ready}), 32'(grants[i]));
      if (i > 0) chk("rr_wea", 32'(wea), 1);
      cyc();
    end
    r0_valid = 0; r1_valid = 0;
    #2;
    chk("rr_wea4", 32'(wea), 1);
    chk("rr_addr4", 32'(addra), 20);
    cyc();

    // Single loader write.
    r0_valid = 1; r0_addr = 5; r0_data = 12'hF00;
    #2;
    chk("t1_ready", 32'(r0_ready), 1);
    cyc();
    r0_valid = 0;
    #2;
    chk("t1_wea", 32'(wea), 1);
    chk("t1_addra", 32'(addra), 5);
    chk("t1_dina", 32'(dina), 12'hF00);
    cyc();
    #2;
    chk("t1_idle", 32'(wea), 0);
    cyc();

    // Out-of-range write is accepted and dropped.
    r1_valid = 1; r1_addr = AW'(D); r1_data = 12'h123;
    #2;
    chk("oob_ready", 32'(r1_ready), 1);
    cyc();
    r1_valid = 0;
    #2;
    chk("oob_wea", 32'(wea), 0);
    chk("oob_pulse", 32'(oob_drop), 1);
    cyc();
    #2;
    chk("oob_clear", 32'(oob_drop), 0);
    cyc();

    // Clear coincident with a held r1 request.
    clr_start = 1; clr_color = 12'h00F;
    r1_valid = 1; r1_addr = 33; r1_data = 12'h0A0;
    #2;
    chk("clr_r1_ready", 32'(r1_ready), 0);
    cyc();
    clr_start = 0;
    busy_cnt = 0; good = 0; first_rdy = -1; exp_a = 0;
    for (int k = 0; k < D + 3; k++) begin
      bit seen;
      #2;
      seen = r1_ready;
      if (clr_busy) busy_cnt++;
      if (wea && int'(addra) == exp_a && dina == 12'h00F && exp_a < D) begin
        good++; exp_a++;
      end
      if (seen && first_rdy < 0) first_rdy = k;
      cyc();
      if (seen) r1_valid = 0;
    end
    chk("clr_busy_len", 32'(busy_cnt), D);
    chk("clr_writes", 32'(good), D);
    chk("clr_r1_after", 32'(first_rdy), D - 1);

    // Reset in the middle of a clear.
    clr_start = 1; clr_color = 12'h0F0;
    cyc();
    clr_start = 0;
    found = 0;
    for (int k = 0; k < D && !found; k++) begin
      #2;
      if (wea && addra == AW'(1000)) found = 1;
      else cyc();
    end
    chk("rst_mid_reach", 32'(found), 1);
    rst = 1;
    cyc();
    rst = 0;
    #2;
    chk("rst_mid_busy", 32'(clr_busy), 0);
    chk("rst_mid_wea", 32'(wea), 0);
    r0_valid = 1; r0_addr = 1; r0_data = 12'h321;
    #1;
    chk("rst_mid_arb", 32'(r0_ready), 1);
    cyc();
    r0_valid = 0;
    #2;
    chk("rst_mid_wr", 32'(addra), 1);
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
